// File: rtl/alu_muldiv_seq.sv
// Iterative radix-2 multiply/divide unit (MUL, IMUL, DIV, IDIV) with a half-width mode.
// PREP turns the operands into magnitudes and screens divides. ITER runs one bit per cycle.
// FIX applies the signs and the flags, and DONE presents the results for one cycle.
module alu_muldiv_seq #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             abort,
    input  logic [1:0]       op,
    input  logic             is_8_bit,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] a_hi,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic             cf_of,
    output logic             div_error
);

    localparam int unsigned W  = WIDTH;
    localparam int unsigned H  = WIDTH / 2;
    localparam int unsigned W2 = 2 * WIDTH;
    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_ITER,
        S_FIX,
        S_DONE
    } state_t;

    state_t          state_q;
    logic [1:0]      op_q;
    logic            half_q;
    logic [W-1:0]    a_q, ahi_q, b_q;
    logic [W2-1:0]   mcand_q, prod_q;
    logic [W-1:0]    mplier_q;
    logic [W-1:0]    rem_q, quo_q, dvsr_q;
    logic            neg_lo_q, neg_hi_q;
    logic [CW-1:0]   cnt_q;
    logic            busy_q, done_q, cf_q, err_q;
    logic [W-1:0]    res_lo_q, res_hi_q;

    // Sign bit of an operand at the active width (bit N-1)
    function automatic logic msb_n(input logic [W-1:0] x, input logic half);
        return half ? x[H-1] : x[W-1];
    endfunction

    logic [W-1:0]  in_mask, mask_n;
    logic [W2-1:0] mask_2n;

    // Operand masks for the incoming and the latched width
    always_comb begin
        in_mask = is_8_bit ? {{(W-H){1'b0}}, {H{1'b1}}} : {W{1'b1}};
        mask_n  = half_q   ? {{(W-H){1'b0}}, {H{1'b1}}} : {W{1'b1}};
        mask_2n = half_q   ? {{W{1'b0}}, {W{1'b1}}}     : {W2{1'b1}};
    end

    logic          is_div, is_sgn, a_neg, b_neg, div_zero, div_ovf;
    logic [W-1:0]  a_mag, b_mag, dvd_hi, dvd_lo;
    logic [W2-1:0] dvd_raw, dvd_mag;

    // PREP: magnitudes, result signs and the early divide fault checks
    always_comb begin
        is_div   = op_q[1];
        is_sgn   = op_q[0];
        a_neg    = is_sgn & msb_n(is_div ? ahi_q : a_q, half_q);
        b_neg    = is_sgn & msb_n(b_q, half_q);
        a_mag    = a_neg ? ((-a_q) & mask_n) : a_q;
        b_mag    = b_neg ? ((-b_q) & mask_n) : b_q;
        dvd_raw  = half_q ? {{W{1'b0}}, ahi_q[H-1:0], a_q[H-1:0]} : {ahi_q, a_q};
        dvd_mag  = a_neg ? ((-dvd_raw) & mask_2n) : dvd_raw;
        dvd_hi   = half_q ? W'(dvd_mag[W-1:H]) : dvd_mag[W2-1:W];
        dvd_lo   = half_q ? W'(dvd_mag[H-1:0]) : dvd_mag[W-1:0];
        div_zero = (b_q == '0);
        // A high half not below the divisor means a quotient wider than N bits
        div_ovf  = (dvd_hi >= b_mag);
    end

    logic [W2-1:0] prod_nx;
    logic [W:0]    rem_sh;
    logic          rem_ge;
    logic [W-1:0]  rem_nx;

    // ITER: one shift-add step or one restoring shift-subtract step
    always_comb begin
        prod_nx = mplier_q[0] ? (prod_q + mcand_q) : prod_q;
        rem_sh  = {rem_q, msb_n(quo_q, half_q)};
        rem_ge  = (rem_sh >= {1'b0, dvsr_q});
        rem_nx  = rem_ge ? W'(rem_sh - {1'b0, dvsr_q}) : rem_sh[W-1:0];
    end

    logic [W2-1:0] p_fix;
    logic [W-1:0]  p_hi, p_lo, q_mag, q_fix, r_fix;
    logic [W-1:0]  fix_lo, fix_hi;
    logic          mul_cf, q_ovf, fix_err, fix_cf;

    // FIX: sign correction, flags and the signed-quotient range check
    always_comb begin
        p_fix  = neg_lo_q ? ((-prod_q) & mask_2n) : prod_q;
        p_hi   = half_q ? W'(p_fix[W-1:H]) : p_fix[W2-1:W];
        p_lo   = half_q ? W'(p_fix[H-1:0]) : p_fix[W-1:0];
        mul_cf = is_sgn ? (p_hi != (msb_n(p_lo, half_q) ? mask_n : '0))
                        : (p_hi != '0);
        q_mag  = quo_q & mask_n;
        // Magnitude 2^(N-1) or above does not fit the symmetric signed range
        q_ovf  = is_sgn & msb_n(q_mag, half_q);
        q_fix  = neg_lo_q ? ((-q_mag) & mask_n) : q_mag;
        r_fix  = neg_hi_q ? ((-rem_q) & mask_n) : rem_q;
        fix_err = is_div & q_ovf;
        fix_cf  = ~is_div & mul_cf;
        fix_lo  = '0;
        fix_hi  = '0;
        if (!fix_err) begin
            fix_lo = is_div ? q_fix : p_lo;
            fix_hi = is_div ? r_fix : p_hi;
        end
    end

    // Sequencer FSM, operand latch, iteration datapath and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            half_q   <= 1'b0;
            a_q      <= '0;
            ahi_q    <= '0;
            b_q      <= '0;
            mcand_q  <= '0;
            prod_q   <= '0;
            mplier_q <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvsr_q   <= '0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            cf_q     <= 1'b0;
            err_q    <= 1'b0;
            res_lo_q <= '0;
            res_hi_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        op_q    <= op;
                        half_q  <= is_8_bit;
                        a_q     <= a & in_mask;
                        ahi_q   <= a_hi & in_mask;
                        b_q     <= b & in_mask;
                        busy_q  <= 1'b1;
                        state_q <= S_PREP;
                    end
                end
                S_PREP: begin
                    if (abort) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else if (is_div && (div_zero || div_ovf)) begin
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        res_lo_q <= '0;
                        res_hi_q <= '0;
                        cf_q     <= 1'b0;
                        err_q    <= 1'b1;
                        state_q  <= S_DONE;
                    end else begin
                        mcand_q  <= W2'(a_mag);
                        mplier_q <= b_mag;
                        prod_q   <= '0;
                        rem_q    <= dvd_hi;
                        quo_q    <= dvd_lo;
                        dvsr_q   <= b_mag;
                        neg_lo_q <= a_neg ^ b_neg;
                        neg_hi_q <= a_neg;
                        cnt_q    <= half_q ? CW'(H - 1) : CW'(W - 1);
                        state_q  <= S_ITER;
                    end
                end
                S_ITER: begin
                    if (abort) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        if (is_div) begin
                            rem_q <= rem_nx;
                            quo_q <= {quo_q[W-2:0], rem_ge};
                        end else begin
                            prod_q   <= prod_nx;
                            mcand_q  <= mcand_q << 1;
                            mplier_q <= mplier_q >> 1;
                        end
                        if (cnt_q == '0) begin
                            state_q <= S_FIX;
                        end else begin
                            cnt_q <= cnt_q - CW'(1);
                        end
                    end
                end
                S_FIX: begin
                    busy_q <= 1'b0;
                    if (abort) begin
                        state_q <= S_IDLE;
                    end else begin
                        done_q   <= 1'b1;
                        res_lo_q <= fix_lo;
                        res_hi_q <= fix_hi;
                        cf_q     <= fix_cf;
                        err_q    <= fix_err;
                        state_q  <= S_DONE;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign result_lo = res_lo_q;
    assign result_hi = res_hi_q;
    assign cf_of     = cf_q;
    assign div_error = err_q;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Scoreboard bench for alu_muldiv_seq: directed cases plus random operations against an arithmetic model.
module tb_alu_muldiv_seq;

    localparam int unsigned W = 16;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic [1:0]   op = '0;
    logic         is_8_bit = 1'b0;
    logic [W-1:0] a = '0, a_hi = '0, b = '0;
    logic         busy, done, cf_of, div_error;
    logic [W-1:0] result_lo, result_hi;

    alu_muldiv_seq #(.WIDTH(W)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .op(op),
        .is_8_bit(is_8_bit), .a(a), .a_hi(a_hi), .b(b), .busy(busy), .done(done),
        .result_lo(result_lo), .result_hi(result_hi), .cf_of(cf_of), .div_error(div_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] lo;
        logic [15:0] hi;
        logic        cf;
        logic        err;
        int          lat;
        int          t0;
    } exp_t;

    exp_t sbq[$];
    exp_t last_e;
    exp_t mon_e;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic longint labs(input longint x);
        return (x < 0) ? -x : x;
    endfunction

    // Reference: plain integer arithmetic on the N-bit interpretation of the operands
    function automatic exp_t model(input logic [1:0] o, input logic h,
                                   input logic [15:0] va, input logic [15:0] vh,
                                   input logic [15:0] vb);
        exp_t   e;
        int     n;
        longint full, m, mx, ua, uh, ub, sa, sb, d, sd, p, q, r;
        n    = h ? 8 : 16;
        full = longint'(1) << n;
        m    = full - 1;
        mx   = (full / 2) - 1;
        ua   = longint'(va) & m;
        uh   = longint'(vh) & m;
        ub   = longint'(vb) & m;
        sa   = (ua > mx) ? ua - full : ua;
        sb   = (ub > mx) ? ub - full : ub;
        d    = (uh << n) | ua;
        sd   = (d >= (full << (n - 1))) ? d - (full << n) : d;
        e.lo = '0; e.hi = '0; e.cf = 1'b0; e.err = 1'b0; e.lat = n + 3; e.t0 = 0;
        case (o)
            2'd0: begin
                p    = ua * ub;
                e.lo = 16'(p & m);
                e.hi = 16'((p >> n) & m);
                e.cf = ((p >> n) != 0);
            end
            2'd1: begin
                p    = sa * ub;
                p    = sa * sb;
                e.lo = 16'(p & m);
                e.hi = 16'((p >> n) & m);
                e.cf = (p > mx) || (p < -(mx + 1));
            end
            2'd2: begin
                if (ub == 0 || (d / ub) > m) begin
                    e.err = 1'b1; e.lat = 2;
                end else begin
                    e.lo = 16'(d / ub);
                    e.hi = 16'(d % ub);
                end
            end
            default: begin
                if (sb == 0 || (labs(sd) / labs(sb)) > m) begin
                    e.err = 1'b1; e.lat = 2;
                end else begin
                    q = sd / sb;
                    r = sd % sb;
                    if (q > mx || q < -mx) begin
                        e.err = 1'b1;
                    end else begin
                        e.lo = 16'(q & m);
                        e.hi = 16'(r & m);
                    end
                end
            end
        endcase
        return e;
    endfunction

    // Monitor: every done pulse is matched against the oldest expectation
    always @(negedge clk) begin
        if (reset_n && done) begin
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got done=1 expected no done (cycle %0d)", cyc);
            end else begin
                mon_e = sbq.pop_front();
                chk("result_lo", result_lo, mon_e.lo);
                chk("result_hi", result_hi, mon_e.hi);
                chk("cf_of", cf_of, mon_e.cf);
                chk("div_error", div_error, mon_e.err);
                chk("latency", cyc - mon_e.t0, mon_e.lat);
                chk("busy_at_done", busy, 0);
            end
        end
    end

    task automatic wait_drain();
        for (int i = 0; i < 40 && sbq.size() != 0; i++) @(negedge clk);
        if (sbq.size() != 0) begin
            chk("done_timeout", sbq.size(), 0);
            sbq.delete();
        end
    endtask

    task automatic scramble_inputs();
        a        = 16'($urandom);
        a_hi     = 16'($urandom);
        b        = 16'($urandom);
        op       = 2'($urandom);
        is_8_bit = 1'($urandom);
    endtask

    task automatic issue(input logic [1:0] o, input logic h, input logic [15:0] va,
                         input logic [15:0] vh, input logic [15:0] vb, input logic ab);
        exp_t e;
        e = model(o, h, va, vh, vb);
        @(negedge clk);
        op = o; is_8_bit = h; a = va; a_hi = vh; b = vb; start = 1'b1; abort = ab;
        e.t0 = cyc;
        sbq.push_back(e);
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        scramble_inputs();
        chk("busy_after_start", busy, 1);
        wait_drain();
        last_e = e;
    endtask

    task automatic check_hold(input string tag);
        chk({tag, "_lo"}, result_lo, last_e.lo);
        chk({tag, "_hi"}, result_hi, last_e.hi);
        chk({tag, "_cf"}, cf_of, last_e.cf);
        chk({tag, "_err"}, div_error, last_e.err);
    endtask

    initial begin
        exp_t e;
        logic [1:0]  ro;
        logic        rh;
        logic [15:0] ra, rhv, rb;

        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_lo", result_lo, 0);
        chk("rst_hi", result_hi, 0);
        chk("rst_flags", {cf_of, div_error}, 0);
        reset_n = 1'b1;

        // Full-width unsigned multiply, all ones
        issue(2'd0, 1'b0, 16'hFFFF, 16'h0000, 16'hFFFF, 1'b0);

        // Async reset in the middle of an iteration
        @(negedge clk);
        op = 2'd1; is_8_bit = 1'b0; a = 16'h1234; b = 16'h0F0F; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_lo", result_lo, 0);
        chk("arst_hi", result_hi, 0);
        chk("arst_flags", {cf_of, div_error}, 0);
        @(negedge clk);
        reset_n = 1'b1;

        // Half-width signed multiply, -2 * 3
        issue(2'd1, 1'b1, 16'h00FE, 16'h0000, 16'h0003, 1'b0);
        // Unsigned divide, then divide by zero and quotient overflow
        issue(2'd2, 1'b0, 16'h0000, 16'h0001, 16'h0010, 1'b0);
        issue(2'd2, 1'b0, 16'h0000, 16'h0001, 16'h0000, 1'b0);
        issue(2'd2, 1'b0, 16'h0000, 16'h0001, 16'h0001, 1'b0);
        // Signed divide -7 / 2, then a quotient of -2^(N-1)
        issue(2'd3, 1'b0, 16'hFFF9, 16'hFFFF, 16'h0002, 1'b0);
        issue(2'd3, 1'b0, 16'h8000, 16'h0000, 16'hFFFF, 1'b0);
        issue(2'd3, 1'b1, 16'h0080, 16'h0000, 16'h00FF, 1'b0);
        // Start and abort together in IDLE: start wins
        issue(2'd0, 1'b1, 16'h00AB, 16'h0000, 16'h00CD, 1'b1);

        // Start raised during the DONE cycle is ignored
        e = model(2'd1, 1'b0, 16'h7FFF, 16'h0000, 16'h7FFF);
        @(negedge clk);
        op = 2'd1; is_8_bit = 1'b0; a = 16'h7FFF; a_hi = '0; b = 16'h7FFF; start = 1'b1;
        e.t0 = cyc;
        sbq.push_back(e);
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 30 && !done; i++) @(negedge clk);
        chk("done_seen", done, 1);
        start = 1'b1; op = 2'd0; a = 16'h0005; b = 16'h0005;
        @(negedge clk);
        start = 1'b0;
        chk("start_in_done_busy", busy, 0);
        repeat (25) @(negedge clk);
        last_e = e;

        // Abort mid-iteration with a stray start while busy
        @(negedge clk);
        op = 2'd0; is_8_bit = 1'b0; a = 16'h1234; b = 16'h0077; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        start = 1'b1; a = 16'h4321;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        abort = 1'b1;
        chk("abort_busy_before", busy, 1);
        @(negedge clk);
        abort = 1'b0;
        chk("abort_idle", busy, 0);
        check_hold("abort_hold");
        repeat (25) @(negedge clk);
        check_hold("abort_hold_late");
        issue(2'd0, 1'b0, 16'h0102, 16'h0000, 16'h0304, 1'b0);

        // Random operations, divide high halves biased toward legal quotients
        for (int k = 0; k < 60; k++) begin
            ro  = 2'($urandom);
            rh  = 1'($urandom);
            ra  = 16'($urandom);
            rb  = 16'($urandom);
            rhv = 16'($urandom);
            if (ro[1] && $urandom_range(0, 3) != 0) begin
                if (ro[0]) rhv = ($urandom_range(0, 1) == 1) ? 16'hFFFF : 16'h0000;
                else       rhv = 16'($urandom_range(0, 3));
            end
            issue(ro, rh, ra, rhv, rb, 1'b0);
        end

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", sbq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
